// File: rtl/mem_data_memory_ctrl.sv
// Big-endian byte-addressed data memory for the MEM stage with a request/response handshake.
// Optional define MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of splitting them byte-wise.
module mem_data_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        addr_err,
    output logic        stall
);

    localparam int unsigned MEM_BYTES = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               go_resp;
    logic               accept;

    logic               cap_write;
    logic [1:0]         cap_size;
    logic               cap_unsign;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;

    logic               acc_write;
    logic [1:0]         acc_size;
    logic               acc_unsign;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;

    logic [2:0]         nbytes;
    logic [32:0]        last_byte;
    logic               range_err;
    logic               align_err;
    logic               acc_err;
    logic               sext;

    logic [ADDR_WIDTH-1:0] idx [4];
    logic [7:0]         rb [4];
    logic [7:0]         wb [4];
    logic [3:0]         wen;
    logic [31:0]        load_data;
    logic [31:0]        rdata_nxt;

    logic [7:0]         ram [MEM_BYTES];

    assign req_ready = (state != WAIT);
    assign stall     = req_valid & ~req_ready;
    assign accept    = req_valid & req_ready;

    // Next-state and response-edge decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_resp   = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the accept edge, so use the live request
    always_comb begin
        acc_write  = req_write;
        acc_size   = req_size;
        acc_unsign = req_unsign;
        acc_addr   = req_addr;
        acc_wdata  = req_wdata;
        if (state == WAIT) begin
            acc_write  = cap_write;
            acc_size   = cap_size;
            acc_unsign = cap_unsign;
            acc_addr   = cap_addr;
            acc_wdata  = cap_wdata;
        end
    end

    // Range / size / alignment checking; no wrap-around past the top of memory
    always_comb begin
        case (acc_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last_byte = {1'b0, acc_addr} + 33'(nbytes - 3'd1);
        range_err = |last_byte[32:ADDR_WIDTH];
`ifdef MEM_ALIGN_CHECK_EN
        align_err = ((acc_size == 2'b01) & acc_addr[0]) |
                    ((acc_size == 2'b10) & (|acc_addr[1:0]));
`else
        align_err = 1'b0;
`endif
        acc_err   = (acc_size == 2'b11) | range_err | align_err;
    end

    // Byte lanes: lane 0 is the byte at addr (most significant of the field)
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = acc_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
            rb[k]  = ram[idx[k]];
            wb[k]  = 8'h00;
        end
        wen  = 4'b0000;
        sext = ~acc_unsign;
        case (acc_size)
            2'b00: begin
                wen       = 4'b0001;
                wb[0]     = acc_wdata[7:0];
                load_data = {{24{sext & rb[0][7]}}, rb[0]};
            end
            2'b01: begin
                wen       = 4'b0011;
                wb[0]     = acc_wdata[15:8];
                wb[1]     = acc_wdata[7:0];
                load_data = {{16{sext & rb[0][7]}}, rb[0], rb[1]};
            end
            2'b10: begin
                wen       = 4'b1111;
                wb[0]     = acc_wdata[31:24];
                wb[1]     = acc_wdata[23:16];
                wb[2]     = acc_wdata[15:8];
                wb[3]     = acc_wdata[7:0];
                load_data = {rb[0], rb[1], rb[2], rb[3]};
            end
            default: load_data = 32'h0;
        endcase
        rdata_nxt = (acc_write | acc_err) ? 32'h0 : load_data;
    end

    // State, capture and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            addr_err   <= 1'b0;
            cap_write  <= 1'b0;
            cap_size   <= 2'b00;
            cap_unsign <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= go_resp;
            rsp_rdata <= go_resp ? rdata_nxt : 32'h0;
            addr_err  <= go_resp & acc_err;
            if (accept) begin
                cap_write  <= req_write;
                cap_size   <= req_size;
                cap_unsign <= req_unsign;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
            end
        end
    end

    // Store commit on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && go_resp && acc_write && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wen[k]) ram[idx[k]] <= wb[k];
            end
        end
    end

endmodule

// File: tb/tb_mem_data_memory_ctrl.sv
// Directed bench for mem_data_memory_ctrl: three instances with LATENCY 1, 3 and 4.
// Expected values follow MEM_ALIGN_CHECK_EN when the same define is applied to the build.
module tb_mem_data_memory_ctrl;

    logic        clk;
    logic        reset;
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        v     [3];
    logic        rdy   [3];
    logic        rv    [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        stl   [3];

    int errors = 0;
    int checks = 0;
    int lat_exp [3] = '{1, 3, 4};

    mem_data_memory_ctrl #(.ADDR_WIDTH(12), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]),
        .req_write(w), .req_size(sz), .req_unsign(uns), .req_addr(a), .req_wdata(wd),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .addr_err(err[0]), .stall(stl[0]));

    mem_data_memory_ctrl #(.ADDR_WIDTH(12), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]),
        .req_write(w), .req_size(sz), .req_unsign(uns), .req_addr(a), .req_wdata(wd),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .addr_err(err[1]), .stall(stl[1]));

    mem_data_memory_ctrl #(.ADDR_WIDTH(12), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(v[2]), .req_ready(rdy[2]),
        .req_write(w), .req_size(sz), .req_unsign(uns), .req_addr(a), .req_wdata(wd),
        .rsp_valid(rv[2]), .rsp_rdata(rdata[2]), .addr_err(err[2]), .stall(stl[2]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to instance d and wait (bounded) for its response
    task automatic acc(input int d, input logic wr, input logic [1:0] s, input logic u,
                       input logic [31:0] ad, input logic [31:0] wdat,
                       output logic [31:0] rd, output logic er, output int lat);
        w = wr; sz = s; uns = u; a = ad; wd = wdat; v[d] = 1'b1;
        @(posedge clk); #1;
        v[d] = 1'b0;
        lat = 1;
        while (rv[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata[d];
        er = err[d];
    endtask

    task automatic ld(input int d, input logic [1:0] s, input logic u, input logic [31:0] ad,
                      input logic [31:0] exp, input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(d, 1'b0, s, u, ad, 32'h0, rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp[d]));
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic st(input int d, input logic [1:0] s, input logic [31:0] ad,
                      input logic [31:0] data, input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        acc(d, 1'b1, s, 1'b0, ad, data, rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp[d]));
        check({tag, "_data"}, rd, 32'h0);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        int seen;
        clk = 1'b0;
        reset = 1'b1;
        w = 1'b0; sz = 2'b00; uns = 1'b0; a = 32'h0; wd = 32'h0;
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_rv", i), 32'(rv[i]), 32'h0);
            check($sformatf("rst%0d_rdata", i), rdata[i], 32'h0);
            check($sformatf("rst%0d_err", i), 32'(err[i]), 32'h0);
            check($sformatf("rst%0d_ready", i), 32'(rdy[i]), 32'h1);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // T1: big-endian loads with sign/zero extension
        st(0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, "t1_sw");
        ld(0, 2'b00, 1'b0, 32'h10, 32'hFFFFFFDE, 1'b0, "t1_lb");
        ld(0, 2'b00, 1'b1, 32'h11, 32'h000000AD, 1'b0, "t1_lbu");
        ld(0, 2'b01, 1'b0, 32'h12, 32'hFFFFBEEF, 1'b0, "t1_lh");
        ld(0, 2'b01, 1'b1, 32'h12, 32'h0000BEEF, 1'b0, "t1_lhu");
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "t1_lw");

        // T2: partial stores touch only their bytes
        st(0, 2'b10, 32'h20, 32'h11223344, 1'b0, "t2_sw");
        st(0, 2'b00, 32'h20, 32'h555555AB, 1'b0, "t2_sb");
        st(0, 2'b01, 32'h22, 32'h6666CDEF, 1'b0, "t2_sh");
        ld(0, 2'b10, 1'b0, 32'h20, 32'hAB22CDEF, 1'b0, "t2_lw");

        // T4: range and size errors at the top of a 4 KiB memory
        st(0, 2'b10, 32'hFFC, 32'h01020304, 1'b0, "t4_sw_top");
        ld(0, 2'b10, 1'b0, 32'hFFC, 32'h01020304, 1'b0, "t4_lw_top");
        ld(0, 2'b00, 1'b1, 32'hFFF, 32'h00000004, 1'b0, "t4_lbu_fff");
        ld(0, 2'b10, 1'b0, 32'hFFE, 32'h0, 1'b1, "t4_lw_ffe");
        ld(0, 2'b01, 1'b0, 32'hFFF, 32'h0, 1'b1, "t4_lh_fff");
        st(0, 2'b00, 32'h0, 32'h0000005A, 1'b0, "t4_sb0");
        st(0, 2'b00, 32'h1000, 32'h00000077, 1'b1, "t4_sb_oor");
        ld(0, 2'b00, 1'b1, 32'h0, 32'h0000005A, 1'b0, "t4_lbu0_kept");
        ld(0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, "t4_size11_ld");
        st(0, 2'b11, 32'h10, 32'hFFFFFFFF, 1'b1, "t4_size11_st");
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "t4_lw_kept");

        // T5: misaligned word
`ifdef MEM_ALIGN_CHECK_EN
        ld(0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, "t5_lw_mis");
        ld(0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, "t5_lh_mis");
`else
        st(0, 2'b00, 32'h14, 32'h00000099, 1'b0, "t5_sb14");
        ld(0, 2'b10, 1'b0, 32'h11, 32'hADBEEF99, 1'b0, "t5_lw_mis");
        ld(0, 2'b01, 1'b0, 32'h13, 32'hFFFFEF99, 1'b0, "t5_lh_mis");
`endif

        // T3: LATENCY=3 handshake, stall and back-to-back accept in RESP
        st(1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, "t3_sw");
        w = 1'b0; sz = 2'b10; uns = 1'b0; a = 32'h10; v[1] = 1'b1;
        @(posedge clk); #1;
        check("t3_c1_ready", 32'(rdy[1]), 32'h0);
        check("t3_c1_stall", 32'(stl[1]), 32'h1);
        check("t3_c1_rv", 32'(rv[1]), 32'h0);
        a = 32'h44;
        @(posedge clk); #1;
        check("t3_c2_ready", 32'(rdy[1]), 32'h0);
        check("t3_c2_stall", 32'(stl[1]), 32'h1);
        check("t3_c2_rv", 32'(rv[1]), 32'h0);
        @(posedge clk); #1;
        check("t3_c3_rv", 32'(rv[1]), 32'h1);
        check("t3_c3_data", rdata[1], 32'hDEADBEEF);
        check("t3_c3_ready", 32'(rdy[1]), 32'h1);
        check("t3_c3_stall", 32'(stl[1]), 32'h0);
        a = 32'h10;
        @(posedge clk); #1;
        v[1] = 1'b0;
        check("t3_c4_rv", 32'(rv[1]), 32'h0);
        check("t3_c4_ready", 32'(rdy[1]), 32'h0);
        @(posedge clk); #1;
        check("t3_c5_rv", 32'(rv[1]), 32'h0);
        @(posedge clk); #1;
        check("t3_c6_rv", 32'(rv[1]), 32'h1);
        check("t3_c6_data", rdata[1], 32'hDEADBEEF);

        // T6: reset while a LATENCY=4 store waits drops it silently
        st(2, 2'b10, 32'h30, 32'h0, 1'b0, "t6_sw0");
        w = 1'b1; sz = 2'b10; a = 32'h30; wd = 32'hCAFEF00D; v[2] = 1'b1;
        @(posedge clk); #1;
        v[2] = 1'b0;
        seen = 0;
        if (rv[2] === 1'b1) seen++;
        @(posedge clk); #1;
        if (rv[2] === 1'b1) seen++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_rst_ready", 32'(rdy[2]), 32'h1);
        for (int i = 0; i < 6; i++) begin
            if (rv[2] === 1'b1) seen++;
            @(posedge clk); #1;
        end
        check("t6_no_rsp", 32'(seen), 32'h0);
        ld(2, 2'b10, 1'b0, 32'h30, 32'h00000000, 1'b0, "t6_lw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
